fft_control_unit_2: RTL
=======================

FFT_CONTROL_UNIT_2 -- requirements
Module: fft_control_unit_2

Interface
REQ-001 SHALL have parameter N, default 1024: FFT length, power of two, minimum 4.
REQ-002 SHALL have parameter BF_LAT, default 3: butterfly pipeline latency in cycles, minimum 1.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port start_i, input, 1 bit: begin a frame; honoured in IDLE only.
REQ-006 SHALL have port inverse_i, input, 1 bit: 1 selects inverse FFT; sampled with start_i.
REQ-007 SHALL have port dready_i, input, 1 bit: input sample valid during LOAD.
REQ-008 SHALL have port dl_busy_i, input, 1 bit: downstream stall during UNLOAD.
REQ-009 SHALL have port busy_o, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port src_sel_o, output, 1 bit: 0 means BRAM write data is the input sample; 1 means it is the butterfly output.
REQ-011 SHALL have ports bram_addr_x0_o and bram_addr_x1_o, output, log2(N) bits each: BRAM port addresses.
REQ-012 SHALL have ports bram_x0_en_o, bram_x1_en_o, bram_x0_we_o and bram_x1_we_o, output, 1 bit each: BRAM port enables and write enables.
REQ-013 SHALL have port bf_ce_o, output, 1 bit: butterfly clock enable.
REQ-014 SHALL have port twiddle_addr_o, output, log2(N)-1 bits: twiddle ROM index.
REQ-015 SHALL have port twiddle_conj_o, output, 1 bit: conjugate the twiddle (inverse mode).
REQ-016 SHALL have port scale_o, output, 1 bit: butterfly divides its result by 2.
REQ-017 SHALL have port fft_ready_o, output, 1 bit: output sample valid on BRAM port x0.
REQ-018 SHALL have port fft_done_o, output, 1 bit: one-cycle end-of-frame pulse.

Function
REQ-019 SHALL implement the FSM states IDLE, LOAD, COMPUTE, UNLOAD and DONE.
REQ-020 IDLE SHALL move to LOAD when start_i=1, registering inverse_i into twiddle_conj_o; twiddle_conj_o SHALL hold until the next start.
REQ-021 In LOAD, each cycle with dready_i=1 SHALL drive bram_x0_en_o=1, bram_x0_we_o=1 and src_sel_o=0, with bram_addr_x0_o = bit-reverse(k), where k counts 0..N-1.
REQ-022 In LOAD, cycles with dready_i=0 SHALL drive no enables and SHALL not advance k; after sample N-1 the FSM SHALL move to COMPUTE.
REQ-023 COMPUTE SHALL cover stage s = 0..log2(N)-1 and butterfly b = 0..N/2-1, with span = 2^s and pos = b mod span.
REQ-024 For each butterfly, a0 = (b div span)*2*span + pos, a1 = a0 + span, and twiddle_addr_o = pos << (log2(N)-1-s).
REQ-025 Each butterfly SHALL take exactly BF_LAT+2 cycles in three phases.
REQ-026 Read phase (1 cycle): both enables 1, both write enables 0, addresses a0/a1, bf_ce_o=1.
REQ-027 Wait phase (BF_LAT cycles): bf_ce_o=1, enables 0.
REQ-028 Write phase (1 cycle): both enables 1, both write enables 1, same addresses, src_sel_o=1.
REQ-029 Total COMPUTE duration SHALL be log2(N)*(N/2)*(BF_LAT+2) cycles.
REQ-030 After the final write phase the FSM SHALL move to UNLOAD.
REQ-031 In UNLOAD, each cycle with dl_busy_i=0 SHALL issue a read on port x0 at address j, where j counts 0..N-1; dl_busy_i=1 SHALL issue no read and hold j.
REQ-032 fft_ready_o SHALL be 1 exactly in the cycle after each issued read (BRAM read latency 1).
REQ-033 The cycle after the last fft_ready_o SHALL be DONE, with fft_done_o=1; the next cycle SHALL be IDLE.
REQ-034 start_i outside IDLE SHALL be ignored.
REQ-035 dl_busy_i outside UNLOAD and dready_i outside LOAD SHALL be ignored.

Reset
REQ-036 rstn=0 at any clock edge SHALL force IDLE, clear k, j, s, b and the phase counter, and drive every output to 0, including mid-frame.
REQ-037 The first cycle after rstn returns to 1 SHALL be IDLE, and start_i SHALL be accepted in that cycle.

Configuration
REQ-038 With macro FFT_CU_SCALE_EN defined, scale_o SHALL equal bf_ce_o during COMPUTE, giving 1/N overall scaling.
REQ-039 Without FFT_CU_SCALE_EN, scale_o SHALL be constant 0 and the port SHALL still exist.

Verification
REQ-040 LOAD order: N=8, start_i with dready_i held 1 -> x0 write addresses 0,4,2,6,1,5,3,7 on 8 consecutive cycles.
REQ-041 Butterfly addressing: N=8, BF_LAT=1 -> stage0 b=1: a0=2, a1=3, tw=0; stage1 b=1: a0=1, a1=3, tw=2; stage2 b=3: a0=3, a1=7, tw=3; COMPUTE lasts 36 cycles.
REQ-042 Backpressure: N=8, dready_i low on alternate LOAD cycles and dl_busy_i high for 3 cycles mid-UNLOAD -> exactly 8 writes, exactly 8 fft_ready_o pulses, addresses unskipped, and one fft_done_o.
REQ-043 Inverse and scale: start_i with inverse_i=1 -> twiddle_conj_o=1 for the whole frame; with FFT_CU_SCALE_EN, scale_o matches bf_ce_o, otherwise scale_o=0.
REQ-044 Reset mid-COMPUTE: rstn=0 for 1 cycle -> all outputs 0 and busy_o=0 next cycle; a new start_i then gives a correct LOAD sequence from address 0.
REQ-045 start_i pulsed during UNLOAD -> no effect, and the frame completes normally.

Source files
------------

// File: rtl/fft_control_unit_2.sv
// fft_control_unit_2: sequencer for an in-place radix-2 FFT (bit-reversed load, staged butterflies, ordered unload).
// Optional feature macro FFT_CU_SCALE_EN: when defined, scale_o follows bf_ce_o during COMPUTE (1/N overall scaling).
module fft_control_unit_2 #(
  parameter int N      = 1024,
  parameter int BF_LAT = 3
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start_i,
  input  logic                   inverse_i,
  input  logic                   dready_i,
  input  logic                   dl_busy_i,
  output logic                   busy_o,
  output logic                   src_sel_o,
  output logic [$clog2(N)-1:0]   bram_addr_x0_o,
  output logic [$clog2(N)-1:0]   bram_addr_x1_o,
  output logic                   bram_x0_en_o,
  output logic                   bram_x1_en_o,
  output logic                   bram_x0_we_o,
  output logic                   bram_x1_we_o,
  output logic                   bf_ce_o,
  output logic [$clog2(N)-2:0]   twiddle_addr_o,
  output logic                   twiddle_conj_o,
  output logic                   scale_o,
  output logic                   fft_ready_o,
  output logic                   fft_done_o
);

  localparam int AW = $clog2(N);
  localparam int BW = AW - 1;
  localparam int SW = $clog2(AW);
  localparam int PW = $clog2(BF_LAT + 2);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_COMPUTE = 3'd2;
  localparam logic [2:0] ST_UNLOAD  = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam logic [AW-1:0] K_LAST = AW'(N - 1);
  localparam logic [BW-1:0] B_LAST = BW'(N / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(AW - 1);
  localparam logic [PW-1:0] PH_RD  = {PW{1'b0}};
  localparam logic [PW-1:0] PH_WR  = PW'(BF_LAT + 1);

  logic [2:0]    r_state;
  logic [AW-1:0] r_k;
  logic [AW-1:0] r_j;
  logic [SW-1:0] r_s;
  logic [BW-1:0] r_b;
  logic [PW-1:0] r_ph;
  logic          r_drain;
  logic          r_conj;
  logic          r_ready;

  logic [AW-1:0] w_span;
  logic [AW-1:0] w_b_ext;
  logic [AW-1:0] w_pos;
  logic [SW:0]   w_s_p1;
  logic [AW-1:0] w_a0;
  logic [AW-1:0] w_a1;
  logic [SW-1:0] w_tw_sh;
  logic [BW-1:0] w_tw;
  logic          w_ul_rd;

  function automatic logic [AW-1:0] bit_rev(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    r = {AW{1'b0}};
    for (int i = 0; i < AW; i++) begin
      r[i] = v[AW-1-i];
    end
    return r;
  endfunction

  // Butterfly pair addresses and twiddle index for stage r_s, butterfly r_b
  always_comb begin
    w_span  = {{(AW-1){1'b0}}, 1'b1} << r_s;
    w_b_ext = {1'b0, r_b};
    w_pos   = w_b_ext & (w_span - {{(AW-1){1'b0}}, 1'b1});
    w_s_p1  = {1'b0, r_s} + {{SW{1'b0}}, 1'b1};
    w_a0    = ((w_b_ext >> r_s) << w_s_p1) | w_pos;
    w_a1    = w_a0 + w_span;
    w_tw_sh = S_LAST - r_s;
    w_tw    = w_pos[BW-1:0] << w_tw_sh;
  end

  assign w_ul_rd = (r_state == ST_UNLOAD) && !r_drain && !dl_busy_i;

  // State, counters and the registered status outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_k     <= {AW{1'b0}};
      r_j     <= {AW{1'b0}};
      r_s     <= {SW{1'b0}};
      r_b     <= {BW{1'b0}};
      r_ph    <= {PW{1'b0}};
      r_drain <= 1'b0;
      r_conj  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_ready <= w_ul_rd;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_state <= ST_LOAD;
            r_conj  <= inverse_i;
            r_k     <= {AW{1'b0}};
          end
        end
        ST_LOAD: begin
          if (dready_i) begin
            if (r_k == K_LAST) begin
              r_state <= ST_COMPUTE;
              r_k     <= {AW{1'b0}};
              r_s     <= {SW{1'b0}};
              r_b     <= {BW{1'b0}};
              r_ph    <= {PW{1'b0}};
            end else begin
              r_k <= r_k + {{(AW-1){1'b0}}, 1'b1};
            end
          end
        end
        ST_COMPUTE: begin
          if (r_ph == PH_WR) begin
            r_ph <= {PW{1'b0}};
            if (r_b == B_LAST) begin
              r_b <= {BW{1'b0}};
              if (r_s == S_LAST) begin
                r_state <= ST_UNLOAD;
                r_s     <= {SW{1'b0}};
                r_j     <= {AW{1'b0}};
                r_drain <= 1'b0;
              end else begin
                r_s <= r_s + {{(SW-1){1'b0}}, 1'b1};
              end
            end else begin
              r_b <= r_b + {{(BW-1){1'b0}}, 1'b1};
            end
          end else begin
            r_ph <= r_ph + {{(PW-1){1'b0}}, 1'b1};
          end
        end
        ST_UNLOAD: begin
          // The drain cycle carries the last fft_ready_o before DONE
          if (r_drain) begin
            r_drain <= 1'b0;
            r_state <= ST_DONE;
          end else if (!dl_busy_i) begin
            if (r_j == K_LAST) begin
              r_j     <= {AW{1'b0}};
              r_drain <= 1'b1;
            end else begin
              r_j <= r_j + {{(AW-1){1'b0}}, 1'b1};
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // BRAM / butterfly strobes decoded from state, phase and the per-cycle qualifiers
  always_comb begin
    src_sel_o      = 1'b0;
    bram_addr_x0_o = {AW{1'b0}};
    bram_addr_x1_o = {AW{1'b0}};
    bram_x0_en_o   = 1'b0;
    bram_x1_en_o   = 1'b0;
    bram_x0_we_o   = 1'b0;
    bram_x1_we_o   = 1'b0;
    bf_ce_o        = 1'b0;
    twiddle_addr_o = {BW{1'b0}};
    case (r_state)
      ST_LOAD: begin
        if (dready_i) begin
          bram_x0_en_o   = 1'b1;
          bram_x0_we_o   = 1'b1;
          bram_addr_x0_o = bit_rev(r_k);
        end else begin
          bram_x0_en_o = 1'b0;
        end
      end
      ST_COMPUTE: begin
        bram_addr_x0_o = w_a0;
        bram_addr_x1_o = w_a1;
        twiddle_addr_o = w_tw;
        if (r_ph == PH_RD) begin
          bram_x0_en_o = 1'b1;
          bram_x1_en_o = 1'b1;
          bf_ce_o      = 1'b1;
        end else if (r_ph == PH_WR) begin
          bram_x0_en_o = 1'b1;
          bram_x1_en_o = 1'b1;
          bram_x0_we_o = 1'b1;
          bram_x1_we_o = 1'b1;
          src_sel_o    = 1'b1;
        end else begin
          bf_ce_o = 1'b1;
        end
      end
      ST_UNLOAD: begin
        if (w_ul_rd) begin
          bram_x0_en_o   = 1'b1;
          bram_addr_x0_o = r_j;
        end else begin
          bram_x0_en_o = 1'b0;
        end
      end
      default: begin
        bf_ce_o = 1'b0;
      end
    endcase
  end

  assign busy_o         = (r_state != ST_IDLE);
  assign fft_done_o     = (r_state == ST_DONE);
  assign fft_ready_o    = r_ready;
  assign twiddle_conj_o = r_conj;

`ifdef FFT_CU_SCALE_EN
  assign scale_o = bf_ce_o;
`else
  assign scale_o = 1'b0;
`endif

endmodule
